// File: rtl/ssd_source_sched.sv
// ssd_source_sched: round-robin share of the seven-segment display among
// three sign-magnitude producers, one dwell period per grant.
module ssd_source_sched #(
  parameter int unsigned DWELL_CNT = 100000000,
  parameter int unsigned CW        = 27
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  REQ_VALID,
  input  logic [29:0] REQ_DATA,
  output logic [2:0]  REQ_READY,
  input  logic        LOCK,
  input  logic        NEXT,
  output logic [9:0]  DOUT,
  output logic [1:0]  DOUT_SEL,
  output logic        DOUT_STB,
  output logic        STALE
);

  localparam logic [CW-1:0] LP_TC = CW'(DWELL_CNT - 1);

  typedef enum logic {
    ARB  = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        r_state;
  logic [1:0]    r_cur;
  logic [CW-1:0] r_dwell;
  logic          r_got;
  logic [9:0]    r_dout;
  logic [1:0]    r_dout_sel;
  logic          r_dout_stb;
  logic          r_stale;

  logic          w_hit;
  logic [1:0]    w_idx;
  logic [9:0]    w_word;
  logic [2:0]    w_ready;
  logic          w_xfer;
  logic          w_tc;
  logic          w_exit;

  // Index reached by stepping k places forward from c, modulo 3.
  function automatic logic [1:0] rot3(input logic [1:0] c, input int unsigned k);
    int unsigned sum;
    sum  = 32'(c) + k;
    rot3 = 2'(sum % 32'd3);
  endfunction

  // Rotated-priority search: cur+1 first, cur itself last.
  always_comb begin
    logic [1:0] cand;
    w_hit = 1'b0;
    w_idx = 2'd0;
    cand  = 2'd0;
    for (int unsigned k = 3; k >= 1; k--) begin
      cand = rot3(r_cur, k);
      if (REQ_VALID[cand]) begin
        w_hit = 1'b1;
        w_idx = cand;
      end
    end
  end

  // Word offered by the currently selected source.
  always_comb begin
    case (r_cur)
      2'd0:    w_word = REQ_DATA[9:0];
      2'd1:    w_word = REQ_DATA[19:10];
      default: w_word = REQ_DATA[29:20];
    endcase
  end

  // Ready depends only on registered state, never on REQ_VALID.
  always_comb begin
    w_ready = 3'b000;
    if (r_state == SHOW) begin
      w_ready = 3'(3'b001 << r_cur);
    end
  end

  assign w_xfer = |(REQ_VALID & w_ready);
  assign w_tc   = (r_dwell == LP_TC);
  assign w_exit = NEXT | (w_tc & ~LOCK);

  // Grant FSM, dwell counter and registered display outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ARB;
      r_cur      <= 2'd2;
      r_dwell    <= '0;
      r_got      <= 1'b0;
      r_dout     <= 10'd0;
      r_dout_sel <= 2'd0;
      r_dout_stb <= 1'b0;
      r_stale    <= 1'b0;
    end else begin
      r_dout_stb <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_hit) begin
            r_cur   <= w_idx;
            r_dwell <= '0;
            r_got   <= 1'b0;
            r_state <= SHOW;
          end
        end
        SHOW: begin
          if (w_xfer) begin
            r_dout     <= w_word;
            r_dout_sel <= r_cur;
            r_dout_stb <= 1'b1;
            r_got      <= 1'b1;
          end
          if (!w_tc) begin
            r_dwell <= r_dwell + CW'(1);
          end
          if (w_exit) begin
            r_stale <= ~(r_got | w_xfer);
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign REQ_READY = w_ready;
  assign DOUT      = r_dout;
  assign DOUT_SEL  = r_dout_sel;
  assign DOUT_STB  = r_dout_stb;
  assign STALE     = r_stale;

endmodule

// File: tb/tb_ssd_source_sched.sv
// tb_ssd_source_sched: randomized and directed stimulus against a
// transaction-level reference of the display scheduler.
module tb_ssd_source_sched;

  localparam int DWELL = 8;

  logic        clk;
  logic        rst;
  logic [2:0]  valid;
  logic [29:0] data;
  logic [2:0]  REQ_READY;
  logic        lock;
  logic        nxt;
  logic [9:0]  DOUT;
  logic [1:0]  DOUT_SEL;
  logic        DOUT_STB;
  logic        STALE;

  int total = 0;
  int bad   = 0;

  ssd_source_sched #(.DWELL_CNT(DWELL), .CW(4)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_DATA(data),
    .REQ_READY(REQ_READY), .LOCK(lock), .NEXT(nxt),
    .DOUT(DOUT), .DOUT_SEL(DOUT_SEL), .DOUT_STB(DOUT_STB), .STALE(STALE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: grant bookkeeping with plain integers and a result queue.
  logic [11:0] exp_q[$];
  bit          m_show  = 1'b0;
  int          m_cur   = 2;
  int          m_dwell = 0;
  bit          m_got   = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_stb   = 1'b0;
  logic [9:0]  m_dout  = 10'd0;

  always @(posedge clk) begin
    bit found;
    bit xfer;
    int idx;
    m_stb = 1'b0;
    if (rst) begin
      m_show = 1'b0; m_cur = 2; m_dwell = 0; m_got = 1'b0;
      m_stale = 1'b0; m_dout = 10'd0;
    end else if (!m_show) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        idx = (m_cur + k) % 3;
        if (!found && valid[idx]) begin
          found = 1'b1; m_cur = idx; m_show = 1'b1; m_dwell = 0; m_got = 1'b0;
        end
      end
    end else begin
      xfer = valid[m_cur];
      if (xfer) begin
        m_dout = data[10*m_cur +: 10];
        exp_q.push_back({2'(m_cur), m_dout});
        m_stb = 1'b1;
      end
      if (nxt || (m_dwell == DWELL - 1 && !lock)) begin
        m_stale = !(m_got || xfer);
        m_show  = 1'b0;
      end else begin
        if (m_dwell < DWELL - 1) m_dwell++;
        if (xfer) m_got = 1'b1;
      end
    end
  end

  // Monitor: per-cycle handshake checks and scoreboard pop on each strobe.
  always @(negedge clk) begin
    logic [11:0] e;
    chk("ready", 32'(REQ_READY), m_show ? 32'(1 << m_cur) : 32'd0);
    chk("ready_onehot0", 32'($onehot0(REQ_READY)), 32'd1);
    chk("stb", 32'(DOUT_STB), 32'(m_stb));
    chk("stale", 32'(STALE), 32'(m_stale));
    if (DOUT_STB === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dout_unexpected: got %0h expected no strobe at %0t", DOUT, $time);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(DOUT), 32'(e[9:0]));
        chk("dout_sel", 32'(DOUT_SEL), 32'(e[11:10]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input int src);
    for (int i = 0; i < 60; i++) begin
      if (REQ_READY[src] === 1'b1) return;
      step();
    end
    total++; bad++;
    $display("FAIL grant_timeout: got %0h expected source %0d granted", REQ_READY, src);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(REQ_READY), 32'd0);
    chk({tag, "_dout"}, 32'(DOUT), 32'd0);
    chk({tag, "_sel"}, 32'(DOUT_SEL), 32'd0);
    chk({tag, "_stb"}, 32'(DOUT_STB), 32'd0);
    chk({tag, "_stale"}, 32'(STALE), 32'd0);
  endtask

  initial begin
    logic [2:0] r;
    rst = 1'b1; valid = 3'b000; data = 30'd0; lock = 1'b0; nxt = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // All three sources valid: rotation 0,1,2,0.
    data = {10'h0FF, 10'h20A, 10'h005};
    valid = 3'b111;
    repeat (4 * 9 + 2) step();
    valid = 3'b000;
    repeat (10) step();

    // Only source 1 valid.
    data[19:10] = 10'h123;
    valid = 3'b010;
    repeat (30) step();
    chk("src1_dout", 32'(DOUT), 32'h123);
    chk("src1_sel", 32'(DOUT_SEL), 32'd1);
    valid = 3'b000;
    repeat (10) step();

    // LOCK holds the grant past terminal count; release exits next cycle.
    data[9:0] = 10'h0AA;
    valid = 3'b001;
    lock = 1'b1;
    wait_grant(0);
    repeat (40) step();
    chk("lock_hold", 32'(REQ_READY), 32'd1);
    lock = 1'b0;
    step();
    chk("lock_release", 32'(REQ_READY), 32'd0);
    lock = 1'b1;
    wait_grant(0);
    repeat (3) step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("next_over_lock", 32'(REQ_READY), 32'd0);
    valid = 3'b000;
    lock = 1'b0;
    repeat (3) step();

    // STALE: empty grant, exit-cycle-only transfer, empty, full transfer.
    data[29:20] = 10'h155;
    valid = 3'b100;
    wait_grant(2);
    valid = 3'b000;
    repeat (10) step();
    chk("stale_empty", 32'(STALE), 32'd1);
    valid = 3'b100;
    wait_grant(2);
    valid = 3'b000;
    repeat (7) step();
    valid = 3'b100;
    step();
    valid = 3'b000;
    chk("stale_exit_xfer", 32'(STALE), 32'd0);
    chk("exit_xfer_dout", 32'(DOUT), 32'h155);
    step();
    valid = 3'b100;
    wait_grant(2);
    valid = 3'b000;
    repeat (10) step();
    chk("stale_empty2", 32'(STALE), 32'd1);
    valid = 3'b100;
    wait_grant(2);
    repeat (8) step();
    valid = 3'b000;
    chk("stale_full", 32'(STALE), 32'd0);
    step();

    // Reset in the middle of a source-1 grant.
    data[19:10] = 10'h2AB;
    valid = 3'b010;
    wait_grant(1);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    valid = 3'b011;
    step();
    chk("post_rst_grant", 32'(REQ_READY), 32'd1);
    valid = 3'b000;
    repeat (12) step();

    // Idle with a NEXT pulse in ARB.
    repeat (20) step();
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    repeat (29) step();
    chk("idle_ready", 32'(REQ_READY), 32'd0);
    chk("idle_dout", 32'(DOUT), 32'(m_dout));

    // Random traffic honouring hold-until-ready.
    for (int n = 0; n < 600; n++) begin
      r = REQ_READY;
      step();
      for (int i = 0; i < 3; i++) begin
        if (!valid[i] || r[i]) begin
          valid[i] = ($urandom_range(0, 2) != 0);
          data[10*i +: 10] = 10'($urandom);
        end
      end
      if ($urandom_range(0, 15) == 0) lock = ~lock;
      nxt = ($urandom_range(0, 11) == 0);
    end
    valid = 3'b000; lock = 1'b0; nxt = 1'b0;
    repeat (20) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
